// File: rtl/coord_pkg.sv
// Shared constants and FSM state type for the coordinate-to-BCD latch.
package coord_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int BCD_W       = 16;
  localparam int DISP_MAX    = 999;
  localparam int N_AXES      = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble step: add 3 to every nibble >= 5, then shift left taking bit_i.
module bcd_dabble_step
  import coord_pkg::*;
(
  input  logic [BCD_W-1:0] scratch_i,
  input  logic             bit_i,
  output logic [BCD_W-1:0] scratch_o
);

  logic [BCD_W-1:0] adj;

  for (genvar gi = 0; gi < BCD_W / 4; gi++) begin : g_nib
    assign adj[gi*4 +: 4] = (scratch_i[gi*4 +: 4] >= 4'd5) ? scratch_i[gi*4 +: 4] + 4'd3
                                                           : scratch_i[gi*4 +: 4];
  end

  assign scratch_o = (adj << 1) | {{(BCD_W-1){1'b0}}, bit_i};

endmodule

// File: rtl/coord_bcd_latch.sv
// Captures x/y/z on frame_start, converts them serially to BCD and commits all three at once.
// Optional macro COORD_CLAMP_999_EN clamps captured operands above 999 to 999.
module coord_bcd_latch
  import coord_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] z,
  output logic [BCD_W-1:0]   x_bcd,
  output logic [BCD_W-1:0]   y_bcd,
  output logic [BCD_W-1:0]   z_bcd,
  output logic               valid,
  output logic               busy,
  output logic               overrun
);

  localparam int                BIT_W    = $clog2(COORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(COORD_W - 1);

  state_t             state_q, state_d;
  logic [1:0]         axis_q, axis_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [COORD_W-1:0] op_q [N_AXES];
  logic [COORD_W-1:0] op_d [N_AXES];
  logic [BCD_W-1:0]   shadow_q [N_AXES];
  logic [BCD_W-1:0]   shadow_d [N_AXES];
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   x_bcd_q, x_bcd_d, y_bcd_q, y_bcd_d, z_bcd_q, z_bcd_d;
  logic               valid_q, valid_d, overrun_q, overrun_d;
  logic [COORD_W-1:0] cur_op;
  logic [BCD_W-1:0]   step_out;

  function automatic logic [COORD_W-1:0] capture(input logic [COORD_W-1:0] v);
`ifdef COORD_CLAMP_999_EN
    if (32'(v) > 32'(DISP_MAX)) return COORD_W'(DISP_MAX);
`endif
    return v;
  endfunction

  always_comb begin
    case (axis_q)
      2'd0:    cur_op = op_q[0];
      2'd1:    cur_op = op_q[1];
      default: cur_op = op_q[2];
    endcase
  end

  bcd_dabble_step u_step (
    .scratch_i (scratch_q),
    .bit_i     (cur_op[COORD_W-1]),
    .scratch_o (step_out)
  );

  always_comb begin
    state_d   = state_q;
    axis_d    = axis_q;
    bit_d     = bit_q;
    scratch_d = scratch_q;
    for (int i = 0; i < N_AXES; i++) begin
      op_d[i]     = op_q[i];
      shadow_d[i] = shadow_q[i];
    end
    x_bcd_d   = x_bcd_q;
    y_bcd_d   = y_bcd_q;
    z_bcd_d   = z_bcd_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          op_d[0]   = capture(x);
          op_d[1]   = capture(y);
          op_d[2]   = capture(z);
          axis_d    = 2'd0;
          bit_d     = '0;
          scratch_d = '0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        if (frame_start) overrun_d = 1'b1;
        for (int i = 0; i < N_AXES; i++) begin
          if (axis_q == 2'(i)) op_d[i] = cur_op << 1;
        end
        if (bit_q == LAST_BIT) begin
          for (int i = 0; i < N_AXES; i++) begin
            if (axis_q == 2'(i)) shadow_d[i] = step_out;
          end
          scratch_d = '0;
          bit_d     = '0;
          if (axis_q == 2'(N_AXES - 1)) state_d = COMMIT;
          else                          axis_d  = axis_q + 2'd1;
        end else begin
          scratch_d = step_out;
          bit_d     = bit_q + 1'b1;
        end
      end
      COMMIT: begin
        if (frame_start) overrun_d = 1'b1;
        // The only place the visible digits change, all three together.
        x_bcd_d = shadow_q[0];
        y_bcd_d = shadow_q[1];
        z_bcd_d = shadow_q[2];
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      axis_q    <= '0;
      bit_q     <= '0;
      scratch_q <= '0;
      for (int i = 0; i < N_AXES; i++) begin
        op_q[i]     <= '0;
        shadow_q[i] <= '0;
      end
      x_bcd_q   <= '0;
      y_bcd_q   <= '0;
      z_bcd_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      axis_q    <= axis_d;
      bit_q     <= bit_d;
      scratch_q <= scratch_d;
      for (int i = 0; i < N_AXES; i++) begin
        op_q[i]     <= op_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      x_bcd_q   <= x_bcd_d;
      y_bcd_q   <= y_bcd_d;
      z_bcd_q   <= z_bcd_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign x_bcd   = x_bcd_q;
  assign y_bcd   = y_bcd_q;
  assign z_bcd   = z_bcd_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: doc/coord_bcd_latch.md
COORD_BCD_LATCH -- requirements
Module: coord_bcd_latch

Interface
REQ-001 The block SHALL have parameter COORD_W, default 10, giving the coordinate width in bits; legal range is 4..13.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse at the start of vertical blanking.
REQ-005 The block SHALL have ports x, y, z, input, COORD_W bits each: live PWM coordinates.
REQ-006 The block SHALL have ports x_bcd, y_bcd, z_bcd, output, 16 bits each: stable BCD digits {thousands, hundreds, tens, ones}, one nibble per digit, for the text renderer.
REQ-007 The block SHALL have port valid, output, 1 bit: high once at least one conversion has been committed.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a capture/conversion is in progress.
REQ-009 The block SHALL have port overrun, output, 1 bit: sticky flag for a frame_start pulse that was ignored.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CONVERT and COMMIT; busy SHALL be 1 in any state other than IDLE.
REQ-011 In IDLE, on an edge with frame_start=1, the block SHALL capture x, y and z into operand registers, set axis=0 and bit=0, and enter CONVERT.
REQ-012 In CONVERT, each edge SHALL perform one double-dabble step (add 3 to every BCD nibble >=5, then shift left one bit, taking the operand MSB) on the current axis.
REQ-013 After the step with bit=COORD_W-1, CONVERT SHALL store the axis result in a shadow register, clear the scratch register and advance axis; after axis 2, CONVERT SHALL enter COMMIT.
REQ-014 In COMMIT, one edge SHALL copy all three shadow values to x_bcd, y_bcd and z_bcd simultaneously, set valid=1 and return to IDLE.
REQ-015 Latency: for frame_start sampled at edge N, outputs SHALL change exactly at edge N+3*COORD_W+1 (N+31 for the default width).
REQ-016 A new frame_start SHALL be accepted at the earliest at edge N+3*COORD_W+2.
REQ-017 Outputs SHALL never change outside COMMIT, so that no frame shows partially updated digits.
REQ-018 frame_start=1 during CONVERT or COMMIT SHALL be ignored, SHALL set overrun=1 and SHALL leave the conversion in progress unaffected.
REQ-019 Changes on x, y or z after capture SHALL have no effect on the conversion in progress.
REQ-020 Every digit nibble SHALL be in the range 0..9; the thousands nibble SHALL be 0 for values below 1000.

Reset
REQ-021 On rst=1, regardless of the clock, the block SHALL force: state=IDLE; x_bcd, y_bcd and z_bcd = 16'h0000; valid=0; busy=0; overrun=0; all operand, scratch and shadow registers cleared.
REQ-022 A reset during CONVERT or COMMIT SHALL discard the partial result, with no commit afterwards.
REQ-023 The block SHALL accept frame_start from the first rising edge after rst deasserts.
REQ-024 overrun SHALL be cleared only by reset.

Configuration
REQ-025 With macro COORD_CLAMP_999_EN defined, each captured operand above 999 SHALL be replaced by 999 at capture time, so the thousands nibble is always 0.
REQ-026 With COORD_CLAMP_999_EN undefined, operands SHALL be converted unmodified to full four-digit BCD.
REQ-027 Latency SHALL be identical with and without COORD_CLAMP_999_EN.

Structure
REQ-028 Shared package coord_pkg SHALL hold: the COORD_W default, the constant BCD_W=16, the constant DISP_MAX=999, and the FSM state enum type.
REQ-029 The per-step add-3-and-shift logic SHALL be a combinational sub-module named bcd_dabble_step (inputs: 16-bit BCD scratch and 1 operand bit; output: next 16-bit BCD scratch).
REQ-030 The top level SHALL contain only the FSM, counters and registers.

Verification
REQ-031 Bench SHALL apply x=123, y=0, z=987 with a frame_start pulse -> at edge N+31: x_bcd=16'h0123, y_bcd=16'h0000, z_bcd=16'h0987, valid=1, busy=0.
REQ-032 Bench SHALL apply x=1023, y=1000, z=999 -> without the macro: x_bcd=16'h1023, y_bcd=16'h1000, z_bcd=16'h0999; with COORD_CLAMP_999_EN: all three = 16'h0999.
REQ-033 Bench SHALL pulse frame_start at N, N+10 and N+31 -> one commit at N+31, overrun=1, and a second pulse at N+32 accepted normally.
REQ-034 Bench SHALL change x from 5 to 700 at N+5 after capture -> committed x_bcd=16'h0005.
REQ-035 Bench SHALL assert rst at N+15 mid-conversion -> all outputs 0 immediately with no clock required, no commit follows, and the next pulse converts correctly.
REQ-036 Bench SHALL sweep all 1024 values on x -> x_bcd matches the decimal reference model and every nibble is <=9.
